// File: rtl/midi_reg_master_if.sv
// Register bus between the MIDI initiator and a register responder.
interface midi_reg_master_if;
   logic [5:0] reg_addr;
   logic       write;
   logic       new_req;
   logic [7:0] write_value;
   logic [7:0] read_value;

   modport master (
      output reg_addr,
      output write,
      output new_req,
      output write_value,
      input  read_value
   );

   modport slave (
      input  reg_addr,
      input  write,
      input  new_req,
      input  write_value,
      output read_value
   );
endinterface

// File: rtl/midi_reg_master.sv
// MIDI byte-stream parser that turns Note-On/Note-Off into register bus writes.
// Note-Off reads the channel register first and only clears it when the
// released note is the one currently enabled.
module midi_reg_master #(
   parameter int unsigned NUM_CH = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                new_rx_data,
   midi_reg_master_if.master   bus,
   output logic                busy,
   output logic                overrun
);

   localparam logic [4:0] CH_LIMIT = 5'(NUM_CH);

   typedef enum logic [2:0] {
      ST_PARSE,
      ST_WR_ON,
      ST_RD,
      ST_RD_WAIT,
      ST_CMP
   } state_t;

   state_t     state_q, state_d;
   logic       valid_q, valid_d;
   logic       cmd_on_q, cmd_on_d;
   logic [3:0] ch_q, ch_d;
   logic [6:0] note_q, note_d;
   logic       phase_d2_q, phase_d2_d;
   logic [5:0] reg_addr_q, reg_addr_d;
   logic       write_q, write_d;
   logic       new_req_q, new_req_d;
   logic [7:0] write_value_q, write_value_d;
   logic       busy_q, busy_d;
   logic       overrun_q, overrun_d;

   // Next-state: parser, command sequencing and bus request generation.
   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      cmd_on_d      = cmd_on_q;
      ch_d          = ch_q;
      note_d        = note_q;
      phase_d2_d    = phase_d2_q;
      reg_addr_d    = reg_addr_q;
      write_d       = write_q;
      write_value_d = write_value_q;
      new_req_d     = 1'b0;
      overrun_d     = new_rx_data && busy_q;

      case (state_q)
         ST_PARSE: begin
            if (new_rx_data) begin
               if (rx_data >= 8'hF8) begin
                  // real-time bytes leave the parser untouched
               end else if (rx_data[7]) begin
                  if ((rx_data[7:5] == 3'b100) && ({1'b0, rx_data[3:0]} < CH_LIMIT)) begin
                     valid_d    = 1'b1;
                     cmd_on_d   = rx_data[4];
                     ch_d       = rx_data[3:0];
                     phase_d2_d = 1'b0;
                  end else begin
                     valid_d = 1'b0;
                  end
               end else if (valid_q) begin
                  if (!phase_d2_q) begin
                     note_d     = rx_data[6:0];
                     phase_d2_d = 1'b1;
                  end else begin
                     phase_d2_d = 1'b0;
                     reg_addr_d = {2'b00, ch_q};
                     new_req_d  = 1'b1;
                     if (cmd_on_q && (rx_data[6:0] != 7'd0)) begin
                        state_d       = ST_WR_ON;
                        write_d       = 1'b1;
                        write_value_d = {1'b1, note_q};
                     end else begin
                        state_d = ST_RD;
                        write_d = 1'b0;
                     end
                  end
               end
            end
         end
         ST_WR_ON:   state_d = ST_PARSE;
         ST_RD:      state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            // read data is valid now; the clearing write goes out while in CMP
            state_d = ST_CMP;
            if (bus.read_value == {1'b1, note_q}) begin
               new_req_d     = 1'b1;
               write_d       = 1'b1;
               write_value_d = {1'b0, note_q};
            end
         end
         ST_CMP:     state_d = ST_PARSE;
         default:    state_d = ST_PARSE;
      endcase

      busy_d = (state_d != ST_PARSE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_PARSE;
         valid_q       <= 1'b0;
         cmd_on_q      <= 1'b0;
         ch_q          <= 4'd0;
         note_q        <= 7'd0;
         phase_d2_q    <= 1'b0;
         reg_addr_q    <= 6'd0;
         write_q       <= 1'b0;
         new_req_q     <= 1'b0;
         write_value_q <= 8'd0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         cmd_on_q      <= cmd_on_d;
         ch_q          <= ch_d;
         note_q        <= note_d;
         phase_d2_q    <= phase_d2_d;
         reg_addr_q    <= reg_addr_d;
         write_q       <= write_d;
         new_req_q     <= new_req_d;
         write_value_q <= write_value_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   assign bus.reg_addr    = reg_addr_q;
   assign bus.write       = write_q;
   assign bus.new_req     = new_req_q;
   assign bus.write_value = write_value_q;
   assign busy            = busy_q;
   assign overrun         = overrun_q;

endmodule
